// File: rtl/pc_flag_ctrl.sv
// rtl/pc_flag_ctrl.sv - WISC-F23 PC, N/Z/V flag register, branch resolve, halt and branch stats
module pc_flag_ctrl #(
   parameter logic [15:0] PC_RESET  = 16'h0000,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic [3:0]           opcode,
   input  logic [2:0]           cond,
   input  logic [8:0]           imm9,
   input  logic [15:0]          br_target,
   input  logic [2:0]           alu_flags,
   input  logic [2:0]           alu_flag_en,
   output logic [15:0]          pc_q,
   output logic [15:0]          pc_plus2,
   output logic [2:0]           flags_q,
   output logic                 taken,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] br_cnt,
   output logic [CNT_WIDTH-1:0] taken_cnt
);

   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [15:0]          pc_d;
   logic [2:0]           flags_d;
   logic                 halted_q, halted_d;
   logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

   logic        flag_n, flag_z, flag_v;
   logic        cond_true;
   logic        is_branch;
   logic        active;
   logic [15:0] b_offset;

   assign flag_n = flags_q[2];
   assign flag_z = flags_q[1];
   assign flag_v = flags_q[0];

   // Decision uses only flags registered by earlier instructions.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         3'b000:  cond_true = ~flag_z;
         3'b001:  cond_true = flag_z;
         3'b010:  cond_true = ~flag_z & ~flag_n;
         3'b011:  cond_true = flag_n;
         3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
         3'b101:  cond_true = flag_n | flag_z;
         3'b110:  cond_true = flag_v;
         default: cond_true = 1'b1;
      endcase
   end

   assign is_branch = (opcode == OP_B) || (opcode == OP_BR);
   assign taken     = cond_true & is_branch & ~halted_q;
   assign active    = ~stall & ~halted_q;
   assign pc_plus2  = pc_q + 16'd2;
   assign b_offset  = {{6{imm9[8]}}, imm9, 1'b0};

   always_comb begin
      pc_d        = pc_q;
      flags_d     = flags_q;
      halted_d    = halted_q;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (active) begin
         if (opcode == OP_HLT) begin
            pc_d     = pc_q;
            halted_d = 1'b1;
         end else if (taken && (opcode == OP_B)) begin
            pc_d = pc_plus2 + b_offset;
         end else if (taken) begin
            pc_d = br_target;
         end else begin
            pc_d = pc_plus2;
         end
         // Masked merge keeps unknown bits of disabled flags out of the register.
         flags_d = (alu_flags & alu_flag_en) | (flags_q & ~alu_flag_en);
         if (is_branch) begin
            if (br_cnt_q != CNT_MAX) begin
               br_cnt_d = br_cnt_q + CNT_ONE;
            end
            if (taken && (taken_cnt_q != CNT_MAX)) begin
               taken_cnt_d = taken_cnt_q + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= PC_RESET;
         flags_q     <= 3'b000;
         halted_q    <= 1'b0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         flags_q     <= flags_d;
         halted_q    <= halted_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign halted    = halted_q;
   assign br_cnt    = br_cnt_q;
   assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_pc_flag_ctrl.sv
// tb/tb_pc_flag_ctrl.sv - scoreboard bench for pc_flag_ctrl with directed vectors
module tb_pc_flag_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall;
   logic [3:0]    opcode;
   logic [2:0]    cond;
   logic [8:0]    imm9;
   logic [15:0]   br_target;
   logic [2:0]    alu_flags;
   logic [2:0]    alu_flag_en;
   logic [15:0]   pc_q;
   logic [15:0]   pc_plus2;
   logic [2:0]    flags_q;
   logic          taken;
   logic          halted;
   logic [CW-1:0] br_cnt;
   logic [CW-1:0] taken_cnt;

   pc_flag_ctrl #(.PC_RESET(16'h0000), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .opcode      (opcode),
      .cond        (cond),
      .imm9        (imm9),
      .br_target   (br_target),
      .alu_flags   (alu_flags),
      .alu_flag_en (alu_flag_en),
      .pc_q        (pc_q),
      .pc_plus2    (pc_plus2),
      .flags_q     (flags_q),
      .taken       (taken),
      .halted      (halted),
      .br_cnt      (br_cnt),
      .taken_cnt   (taken_cnt)
   );

   always #5 clk = ~clk;

   // kind 0: check taken before the edge, state after it; kind 1: check everything at once
   typedef struct {
      bit            kind;
      string         name;
      logic          tk;
      logic [15:0]   pc;
      logic [2:0]    fl;
      logic          h;
      logic [CW-1:0] bc;
      logic [CW-1:0] tc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic push_exp(input bit kind, input string name, input logic e_tk, input logic [15:0] e_pc,
                           input logic [2:0] e_fl, input logic e_h, input int e_bc, input int e_tc);
      exp_t r;
      r.kind = kind;
      r.name = name;
      r.tk   = e_tk;
      r.pc   = e_pc;
      r.fl   = e_fl;
      r.h    = e_h;
      r.bc   = e_bc[CW-1:0];
      r.tc   = e_tc[CW-1:0];
      sb.push_back(r);
   endtask

   task automatic step(input string name, input logic [3:0] op, input logic [2:0] cnd, input logic [8:0] imm,
                       input logic [15:0] tgt, input logic [2:0] af, input logic [2:0] en, input logic stl,
                       input logic e_tk, input logic [15:0] e_pc, input logic [2:0] e_fl, input logic e_h,
                       input int e_bc, input int e_tc);
      @(posedge clk);
      #2;
      opcode      = op;
      cond        = cnd;
      imm9        = imm;
      br_target   = tgt;
      alu_flags   = af;
      alu_flag_en = en;
      stall       = stl;
      push_exp(1'b0, name, e_tk, e_pc, e_fl, e_h, e_bc, e_tc);
   endtask

   task automatic reset_pulse(input string name);
      @(posedge clk);
      #3;
      rst_n       = 1'b0;
      stall       = 1'b1;
      opcode      = 4'h0;
      alu_flag_en = 3'b000;
      #1;
      push_exp(1'b1, name, 1'b0, 16'h0000, 3'b000, 1'b0, 0, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t r;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            r = sb.pop_front();
            n_chk++;
            if (taken === r.tk) n_pass++;
            else $display("FAIL %s taken: got %b want %b", r.name, taken, r.tk);
            if (r.kind == 1'b0) begin
               @(posedge clk);
               #1;
            end
            n_chk++;
            if ({pc_q, flags_q, halted, br_cnt, taken_cnt} === {r.pc, r.fl, r.h, r.bc, r.tc}) n_pass++;
            else $display("FAIL %s state: got pc=%h fl=%b h=%b br=%0d tk=%0d want pc=%h fl=%b h=%b br=%0d tk=%0d",
                          r.name, pc_q, flags_q, halted, br_cnt, taken_cnt, r.pc, r.fl, r.h, r.bc, r.tc);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst_n       = 1'b0;
      stall       = 1'b1;
      opcode      = 4'h0;
      cond        = 3'b000;
      imm9        = 9'h000;
      br_target   = 16'h0000;
      alu_flags   = 3'b000;
      alu_flag_en = 3'b000;
      push_exp(1'b1, "reset", 1'b0, 16'h0000, 3'b000, 1'b0, 0, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      //    name          op     cnd  imm     tgt       af      en      stl  tk pc        fl      h  bc  tc
      step("p1_a",       4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0002, 3'b000, 0, 0,  0);
      step("p1_b",       4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0004, 3'b000, 0, 0,  0);
      step("p1_c",       4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0006, 3'b000, 0, 0,  0);
      step("p2_add",     4'h0, 3'd0, 9'h000, 16'h0000, 3'b101, 3'b111, 0,   0, 16'h0008, 3'b101, 0, 0,  0);
      step("p2_xor_x",   4'h2, 3'd0, 9'h000, 16'h0000, 3'bx1x, 3'b010, 0,   0, 16'h000A, 3'b111, 0, 0,  0);
      step("p3_setfl",   4'h0, 3'd0, 9'h000, 16'h0000, 3'b010, 3'b111, 0,   0, 16'h000C, 3'b010, 0, 0,  0);
      step("p3_adv1",    4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h000E, 3'b010, 0, 0,  0);
      step("p3_adv2",    4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0010, 3'b010, 0, 0,  0);
      step("p3_b_eq",    4'hC, 3'd1, 9'h1FE, 16'h0000, 3'b000, 3'b000, 0,   1, 16'h000E, 3'b010, 0, 1,  1);
      step("p3_adv3",    4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0010, 3'b010, 0, 1,  1);
      step("p3_b_ne",    4'hC, 3'd0, 9'h1FE, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0012, 3'b010, 0, 2,  1);
      step("p4_br",      4'hD, 3'd7, 9'h000, 16'h1234, 3'b000, 3'b000, 0,   1, 16'h1234, 3'b010, 0, 3,  2);
      step("p4_br_fffe", 4'hD, 3'd7, 9'h000, 16'hFFFE, 3'b000, 3'b000, 0,   1, 16'hFFFE, 3'b010, 0, 4,  3);
      step("p4_b_wrap",  4'hC, 3'd7, 9'h001, 16'h0000, 3'b000, 3'b000, 0,   1, 16'h0002, 3'b010, 0, 5,  4);
      step("br_odd",     4'hD, 3'd7, 9'h000, 16'h0011, 3'b000, 3'b000, 0,   1, 16'h0011, 3'b010, 0, 6,  5);
      step("b_gt_no",    4'hC, 3'd2, 9'h010, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0013, 3'b010, 0, 7,  5);
      step("b_ov_no",    4'hC, 3'd6, 9'h010, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0015, 3'b010, 0, 8,  5);
      step("b_le_yes",   4'hC, 3'd5, 9'h002, 16'h0000, 3'b000, 3'b000, 0,   1, 16'h001B, 3'b010, 0, 9,  6);
      step("set_n",      4'h0, 3'd0, 9'h000, 16'h0000, 3'b100, 3'b111, 0,   0, 16'h001D, 3'b100, 0, 9,  6);
      step("b_lt_yes",   4'hC, 3'd3, 9'h003, 16'h0000, 3'b000, 3'b000, 0,   1, 16'h0025, 3'b100, 0, 10, 7);
      step("b_ge_upd",   4'hC, 3'd4, 9'h005, 16'h0000, 3'b001, 3'b111, 0,   0, 16'h0027, 3'b001, 0, 11, 7);
      step("b_ov_yes",   4'hC, 3'd6, 9'h1FF, 16'h0000, 3'b000, 3'b000, 0,   1, 16'h0027, 3'b001, 0, 12, 8);
      for (int i = 0; i < 3; i++)
         step("p5_stall",4'hC, 3'd7, 9'h002, 16'h0000, 3'b010, 3'b111, 1,   1, 16'h0027, 3'b001, 0, 12, 8);
      step("p5_release", 4'hC, 3'd7, 9'h002, 16'h0000, 3'b010, 3'b111, 0,   1, 16'h002D, 3'b010, 0, 13, 9);
      step("p6_br",      4'hD, 3'd7, 9'h000, 16'h0020, 3'b000, 3'b000, 0,   1, 16'h0020, 3'b010, 0, 14, 10);
      step("p6_hlt",     4'hF, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0020, 3'b010, 1, 14, 10);
      for (int i = 0; i < 5; i++)
         step("p6_frozen", (i % 2 == 0) ? 4'hC : 4'h0, 3'd7, 9'h005, 16'h0000, 3'b101, 3'b111, 0,
              0, 16'h0020, 3'b010, 1, 14, 10);
      reset_pulse("p6_reset");
      step("post_rst",   4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   0, 16'h0002, 3'b000, 0, 0,  0);
      for (int i = 1; i <= 17; i++)
         step("sat",     4'hD, 3'd7, 9'h000, 16'h0000, 3'b000, 3'b000, 0,   1, 16'h0000, 3'b000, 0,
              (i > 15) ? 15 : i, (i > 15) ? 15 : i);

      @(posedge clk);
      #2;
      stall = 1'b1;
      for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expected entries left, want 0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
